// File: rtl/axi_mem_pkg.sv
// Shared AXI4 responder types: burst and response encodings, data-path constants.
package axi_mem_pkg;
  localparam int DATA_WIDTH = 128;
  localparam int ADDR_LSB   = 4;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  // FIXED holds the word index; INCR and WRAP both step by one word per beat.
  function automatic logic burst_steps(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction
endpackage

// File: rtl/sdp_ram_be.sv
// Simple dual-port RAM with per-byte write enables and a registered, read-first read port.
module sdp_ram_be
  import axi_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [STRB_WIDTH-1:0] i_wbe,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_q;

  // Read holds its last value when i_re is low so a stalled consumer keeps its beat.
  always_ff @(posedge i_clk) begin
    if (i_re) r_q <= r_mem[i_raddr];
    if (i_we) begin
      for (int k = 0; k < STRB_WIDTH; k++) begin
        if (i_wbe[k]) r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 memory responder: one write and one read burst in flight, independent paths.
// Optional AXI_MEM_RESPONDER_ERR_EN adds DECERR on out-of-range addresses and SLVERR on wlast mismatch.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int ID_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [63:0]           s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic [2:0]            s_awsize,
  input  logic [1:0]            s_awburst,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [ID_WIDTH-1:0]   s_bid,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [63:0]           s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;

  logic                  r_run;
  logic [1:0]            r_wstate;
  logic [7:0]            r_wcnt, r_wlen;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [AW-1:0]         r_widx;
  logic [1:0]            r_wburst;
  logic                  r_wdec, r_wslv;
  resp_e                 r_bresp;
  logic [0:0]            r_rstate;
  logic [8:0]            r_rissued;
  logic [7:0]            r_rlen;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [AW-1:0]         r_ridx;
  logic [1:0]            r_rburst;
  logic                  r_rdec;
  logic                  r_vld_p1, r_last_p1, r_vld_p2, r_rlast_p2;
  resp_e                 r_rresp_p2;
  logic [DATA_WIDTH-1:0] r_rdata_p2;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic w_awhs, w_whs, w_wfinal, w_arhs, w_rhs, w_issue, w_adv_p1, w_adv_p2;
  logic w_aw_dec, w_ar_dec, w_wlast_err, w_unused;

`ifdef AXI_MEM_RESPONDER_ERR_EN
  assign w_aw_dec    = |s_awaddr[63:ADDR_LSB+AW];
  assign w_ar_dec    = |s_araddr[63:ADDR_LSB+AW];
  assign w_wlast_err = s_wlast != w_wfinal;
`else
  assign w_aw_dec    = 1'b0;
  assign w_ar_dec    = 1'b0;
  assign w_wlast_err = 1'b0;
`endif

  // Size, sub-word address bits and (without error checking) high bits and wlast carry no meaning here.
  assign w_unused = ^{s_awsize, s_arsize, s_awaddr[ADDR_LSB-1:0], s_araddr[ADDR_LSB-1:0],
                      s_awaddr[63:ADDR_LSB+AW], s_araddr[63:ADDR_LSB+AW], s_wlast};

  assign s_awready = r_run && (r_wstate == W_IDLE);
  assign s_wready  = (r_wstate == W_DATA);
  assign s_bvalid  = (r_wstate == W_RESP);
  assign s_bid     = r_bid;
  assign s_bresp   = r_bresp;
  assign w_awhs    = s_awvalid && s_awready;
  assign w_whs     = s_wvalid && s_wready;
  assign w_wfinal  = (r_wcnt == r_wlen);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_run    <= 1'b0;
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_wdec   <= 1'b0;
      r_wslv   <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else begin
      r_run <= 1'b1;
      case (r_wstate)
        W_IDLE: if (w_awhs) begin
          r_wstate <= W_DATA;
          r_wcnt   <= '0;
          r_wdec   <= w_aw_dec;
          r_wslv   <= 1'b0;
        end
        W_DATA: if (w_whs) begin
          r_wcnt <= r_wcnt + 8'd1;
          if (w_wlast_err) r_wslv <= 1'b1;
          if (w_wfinal) begin
            r_wstate <= W_RESP;
            r_bresp  <= r_wdec ? RESP_DECERR : ((r_wslv || w_wlast_err) ? RESP_SLVERR : RESP_OKAY);
          end
        end
        W_RESP: if (s_bready) begin
          r_wstate <= W_IDLE;
          r_bresp  <= RESP_OKAY;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_awhs) begin
      r_bid    <= s_awid;
      r_wlen   <= s_awlen;
      r_wburst <= s_awburst;
      r_widx   <= s_awaddr[ADDR_LSB +: AW];
    end else if (w_whs && burst_steps(r_wburst)) begin
      r_widx <= r_widx + AW'(1);
    end
  end

  // Read pipeline: p0 issues the RAM read, p1 is the RAM output, p2 the R output register.
  assign s_arready = r_run && (r_rstate == R_IDLE);
  assign w_arhs    = s_arvalid && s_arready;
  assign w_rhs     = r_vld_p2 && s_rready;
  assign w_issue   = (r_rstate == R_DATA) && (r_rissued <= {1'b0, r_rlen});
  assign w_adv_p2  = !r_vld_p2 || s_rready;
  assign w_adv_p1  = !r_vld_p1 || w_adv_p2;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rstate   <= R_IDLE;
      r_rissued  <= '0;
      r_rdec     <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_last_p1  <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_rlast_p2 <= 1'b0;
      r_rresp_p2 <= RESP_OKAY;
    end else begin
      if (w_arhs) begin
        r_rstate  <= R_DATA;
        r_rissued <= '0;
        r_rdec    <= w_ar_dec;
      end else if (w_rhs && r_rlast_p2) begin
        r_rstate <= R_IDLE;
      end
      if (w_adv_p1) begin
        r_vld_p1  <= w_issue;
        r_last_p1 <= w_issue && (r_rissued == {1'b0, r_rlen});
        if (w_issue) r_rissued <= r_rissued + 9'd1;
      end
      if (w_adv_p2) begin
        r_vld_p2   <= r_vld_p1;
        r_rlast_p2 <= r_vld_p1 && r_last_p1;
        r_rresp_p2 <= (r_vld_p1 && r_rdec) ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_arhs) begin
      r_rid    <= s_arid;
      r_rlen   <= s_arlen;
      r_rburst <= s_arburst;
      r_ridx   <= s_araddr[ADDR_LSB +: AW];
    end else if (w_adv_p1 && w_issue && burst_steps(r_rburst)) begin
      r_ridx <= r_ridx + AW'(1);
    end
    if (w_adv_p2 && r_vld_p1) r_rdata_p2 <= r_rdec ? '0 : w_ram_q;
  end

  assign s_rvalid = r_vld_p2;
  assign s_rdata  = r_rdata_p2;
  assign s_rid    = r_rid;
  assign s_rresp  = r_rresp_p2;
  assign s_rlast  = r_rlast_p2;

  sdp_ram_be #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_whs && !r_wdec),
    .i_waddr (r_widx),
    .i_wbe   (s_wstrb),
    .i_wdata (s_wdata),
    .i_re    (w_adv_p1 && w_issue),
    .i_raddr (r_ridx),
    .o_rdata (w_ram_q)
  );
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed and randomized bursts against a word-array model of the responder's memory.
module tb_axi_mem_responder;
  localparam int MEM_DEPTH = 1024;
  localparam int ID_WIDTH  = 4;
  localparam int AWB       = 10;
`ifdef AXI_MEM_RESPONDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic [ID_WIDTH-1:0] s_awid, s_bid, s_arid, s_rid;
  logic [63:0] s_awaddr, s_araddr;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_arsize;
  logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
  logic s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;
  logic [127:0] s_wdata, s_rdata;
  logic [15:0] s_wstrb;

  axi_mem_responder #(.MEM_DEPTH(MEM_DEPTH), .ID_WIDTH(ID_WIDTH)) dut (
    .clk(clk), .rstn(rstn),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  logic [127:0] model [MEM_DEPTH];
  logic [127:0] wd [256];
  logic [15:0]  ws [256];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit is_dec(input logic [63:0] a);
    return ERR_EN && ((a >> (4 + AWB)) != 64'd0);
  endfunction

  function automatic int beat_idx(input logic [63:0] a, input logic [1:0] burst, input int b);
    int s;
    s = int'((a >> 4) % 64'(MEM_DEPTH));
    if (burst == 2'd0) return s;
    return (s + b) % MEM_DEPTH;
  endfunction

  task automatic write_burst(input logic [3:0] id, input logic [63:0] addr, input int len,
                             input logic [1:0] burst, input int early_last);
    bit hs;
    int t, idx;
    logic [1:0] exp_resp;
    s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awsize = 3'd4; s_awburst = burst; s_awvalid = 1'b1;
    t = 0;
    do begin hs = s_awready; tick(); t++; end while (!hs && t < 100);
    s_awvalid = 1'b0;
    chk("aw_accept", 128'(hs), 128'(1));
    for (int b = 0; b <= len; b++) begin
      s_wdata = wd[b]; s_wstrb = ws[b];
      s_wlast = (early_last >= 0) ? (b == early_last) : (b == len);
      s_wvalid = 1'b1;
      t = 0;
      do begin hs = s_wready; tick(); t++; end while (!hs && t < 100);
      if (!hs) chk("w_accept", 128'(hs), 128'(1));
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    if (!is_dec(addr)) begin
      for (int b = 0; b <= len; b++) begin
        idx = beat_idx(addr, burst, b);
        for (int k = 0; k < 16; k++) if (ws[b][k]) model[idx][8*k +: 8] = wd[b][8*k +: 8];
      end
    end
    exp_resp = is_dec(addr) ? 2'd3 : ((ERR_EN && early_last >= 0 && early_last != len) ? 2'd2 : 2'd0);
    s_bready = 1'b1;
    t = 0;
    while (!s_bvalid && t < 100) begin tick(); t++; end
    chk("bvalid", 128'(s_bvalid), 128'(1));
    chk("bid", 128'(s_bid), 128'(id));
    chk("bresp", 128'(s_bresp), 128'(exp_resp));
    tick();
    s_bready = 1'b0;
    chk("bvalid_clear", 128'(s_bvalid), 128'(0));
    chk("awready_after_b", 128'(s_awready), 128'(1));
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [63:0] addr, input int len,
                            input logic [1:0] burst, input bit toggle);
    logic [127:0] exp [256];
    logic [127:0] sv_data;
    logic [6:0] sv_ctl;
    bit hs, stalled, dec;
    int t, beat, cyc;
    dec = is_dec(addr);
    for (int b = 0; b <= len; b++) exp[b] = dec ? 128'd0 : model[beat_idx(addr, burst, b)];
    s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arsize = 3'd4; s_arburst = burst; s_arvalid = 1'b1;
    t = 0;
    do begin hs = s_arready; tick(); t++; end while (!hs && t < 100);
    s_arvalid = 1'b0;
    chk("ar_accept", 128'(hs), 128'(1));
    t = 0;
    while (!s_rvalid && t < 20) begin tick(); t++; end
    chk("r_latency", 128'(t), 128'(2));
    beat = 0; cyc = 0; stalled = 1'b0; sv_data = '0; sv_ctl = '0;
    while (beat <= len && cyc < 2000) begin
      chk("r_sustain", 128'(s_rvalid), 128'(1));
      if (s_rvalid) begin
        if (stalled) begin
          chk("r_hold_data", s_rdata, sv_data);
          chk("r_hold_ctl", 128'({s_rid, s_rresp, s_rlast}), 128'(sv_ctl));
        end
        s_rready = toggle ? cyc[0] : 1'b1;
        if (s_rready) begin
          chk("rdata", s_rdata, exp[beat]);
          chk("rid", 128'(s_rid), 128'(id));
          chk("rresp", 128'(s_rresp), dec ? 128'd3 : 128'd0);
          chk("rlast", 128'(s_rlast), 128'(beat == len));
          beat++;
          stalled = 1'b0;
        end else begin
          sv_data = s_rdata;
          sv_ctl = {s_rid, s_rresp, s_rlast};
          stalled = 1'b1;
        end
      end else begin
        s_rready = 1'b0;
      end
      tick();
      cyc++;
    end
    s_rready = 1'b0;
    chk("r_beats", 128'(beat), 128'(len + 1));
    chk("r_idle", 128'(s_rvalid), 128'(0));
    chk("arready_after_r", 128'(s_arready), 128'(1));
  endtask

  initial begin
    logic [63:0] a;
    int len;
    logic [1:0] bt;
    bit hs;
    int t;
    rstn = 1'b0;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arvalid = 1'b0;
    s_rready = 1'b0;
    repeat (3) tick();
    chk("rst_awready", 128'(s_awready), 128'(0));
    chk("rst_wready", 128'(s_wready), 128'(0));
    chk("rst_arready", 128'(s_arready), 128'(0));
    chk("rst_bvalid", 128'(s_bvalid), 128'(0));
    chk("rst_rvalid", 128'(s_rvalid), 128'(0));
    chk("rst_rlast", 128'(s_rlast), 128'(0));
    chk("rst_resps", 128'({s_bresp, s_rresp}), 128'(0));
    rstn = 1'b1;
    tick();
    chk("rel_awready", 128'(s_awready), 128'(1));
    chk("rel_arready", 128'(s_arready), 128'(1));

    // Fill the whole memory so every later read has a defined expectation.
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 256; b++) begin wd[b] = rnd128(); ws[b] = 16'hFFFF; end
      write_burst(4'(c), 64'(c * 256 * 16), 255, 2'd1, -1);
    end
    read_burst(4'd5, 64'h1000, 255, 2'd1, 1'b0);

    // Single write and read-back.
    wd[0] = {16{8'hA5}}; ws[0] = 16'hFFFF;
    write_burst(4'd1, 64'h40, 0, 2'd1, -1);
    read_burst(4'd2, 64'h40, 0, 2'd1, 1'b0);
    chk("single_data", model[4], {16{8'hA5}});

    // INCR burst with beat-index data, read back under 1/0 backpressure.
    for (int b = 0; b < 16; b++) begin wd[b] = 128'(b); ws[b] = 16'hFFFF; end
    write_burst(4'd3, 64'h100, 15, 2'd1, -1);
    read_burst(4'd4, 64'h100, 15, 2'd1, 1'b1);

    // Byte strobes.
    wd[0] = '1; ws[0] = 16'hFFFF;
    write_burst(4'd6, 64'h0, 0, 2'd1, -1);
    wd[0] = '0; ws[0] = 16'h000F;
    write_burst(4'd6, 64'h0, 0, 2'd1, -1);
    read_burst(4'd7, 64'h0, 0, 2'd1, 1'b0);
    chk("strobe_model", model[0], {{12{8'hFF}}, 32'h0});

    // Index wrap at the top of memory, FIXED and WRAP bursts.
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); ws[b] = 16'hFFFF; end
    write_burst(4'd8, 64'((MEM_DEPTH - 2) * 16), 3, 2'd1, -1);
    read_burst(4'd9, 64'((MEM_DEPTH - 2) * 16), 3, 2'd1, 1'b1);
    read_burst(4'd9, 64'h0, 1, 2'd1, 1'b0);
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); ws[b] = 16'hFFFF; end
    write_burst(4'd10, 64'h2000, 3, 2'd0, -1);
    chk("fixed_model", model[512], wd[3]);
    read_burst(4'd11, 64'h2000, 3, 2'd0, 1'b1);
    read_burst(4'd11, 64'h2010, 0, 2'd1, 1'b0);
    write_burst(4'd12, 64'h2400, 3, 2'd2, -1);
    read_burst(4'd12, 64'h2400, 3, 2'd2, 1'b0);

    // Randomized bursts.
    for (int i = 0; i < 24; i++) begin
      a = 64'($urandom_range(0, MEM_DEPTH * 16 - 1));
      len = $urandom_range(0, 15);
      bt = 2'($urandom_range(0, 2));
      for (int b = 0; b <= len; b++) begin wd[b] = rnd128(); ws[b] = 16'($urandom); end
      write_burst(4'($urandom), a, len, bt, -1);
      read_burst(4'($urandom), a, len, bt, 1'($urandom));
    end

    // Simultaneous read and write of the same words returns the old contents.
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); ws[b] = 16'hFFFF; end
    fork
      write_burst(4'd13, 64'h3000, 3, 2'd1, -1);
      read_burst(4'd14, 64'h3000, 3, 2'd1, 1'b0);
    join
    read_burst(4'd14, 64'h3000, 3, 2'd1, 1'b0);

    // Out-of-range address and early wlast.
    wd[0] = rnd128(); ws[0] = 16'hFFFF;
    write_burst(4'd15, 64'h100_0000_0500, 0, 2'd1, -1);
    read_burst(4'd1, 64'h100_0000_0500, 0, 2'd1, 1'b0);
    read_burst(4'd1, 64'h500, 0, 2'd1, 1'b0);
    for (int b = 0; b < 4; b++) begin wd[b] = rnd128(); ws[b] = 16'hFFFF; end
    write_burst(4'd2, 64'h600, 3, 2'd1, 1);

    // Reset while beat 3 of an 8-beat read is on the bus.
    s_arid = 4'd3; s_araddr = 64'h800; s_arlen = 8'd7; s_arsize = 3'd4; s_arburst = 2'd1; s_arvalid = 1'b1;
    t = 0;
    do begin hs = s_arready; tick(); t++; end while (!hs && t < 100);
    s_arvalid = 1'b0;
    chk("rst_ar_accept", 128'(hs), 128'(1));
    s_rready = 1'b1;
    t = 0;
    while (!s_rvalid && t < 20) begin tick(); t++; end
    chk("rst_beat1", s_rdata, model[128]);
    tick();
    chk("rst_beat2", s_rdata, model[129]);
    tick();
    chk("rst_beat3_valid", 128'(s_rvalid), 128'(1));
    chk("rst_beat3", s_rdata, model[130]);
    rstn = 1'b0;
    tick();
    chk("midrst_rvalid", 128'(s_rvalid), 128'(0));
    chk("midrst_arready", 128'(s_arready), 128'(0));
    chk("midrst_awready", 128'(s_awready), 128'(0));
    tick();
    rstn = 1'b1;
    tick();
    chk("postrst_arready", 128'(s_arready), 128'(1));
    chk("postrst_awready", 128'(s_awready), 128'(1));
    for (int c = 0; c < 10; c++) begin
      chk("postrst_no_beat", 128'(s_rvalid), 128'(0));
      tick();
    end
    s_rready = 1'b0;
    read_burst(4'd4, 64'h800, 1, 2'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 1024, number of 128-bit words in the backing memory (power of two).
REQ-002 SHALL have parameter ID_WIDTH, default 4, width of the AXI ID fields.
REQ-003 SHALL have port clk  in  1  the single clock; rstn  in  1  reset, synchronous and active-low.
REQ-004 SHALL have AW ports s_awid/s_awaddr/s_awlen/s_awsize/s_awburst/s_awvalid  in  ID_WIDTH/64/8/3/2/1, and s_awready  out  1; these carry the write address.
REQ-005 SHALL have W ports s_wdata/s_wstrb/s_wlast/s_wvalid  in  128/16/1/1, and s_wready  out  1; these carry write data.
REQ-006 SHALL have B ports s_bid/s_bresp/s_bvalid  out  ID_WIDTH/2/1, and s_bready  in  1; these carry the write response.
REQ-007 SHALL have AR ports s_arid/s_araddr/s_arlen/s_arsize/s_arburst/s_arvalid  in  ID_WIDTH/64/8/3/2/1, and s_arready  out  1; these carry the read address.
REQ-008 SHALL have R ports s_rid/s_rdata/s_rresp/s_rlast/s_rvalid  out  ID_WIDTH/128/2/1/1, and s_rready  in  1; these carry read data.

Function
REQ-009 SHALL act as the AXI4 slave/responder: it autonomously serves bursts into internal memory, one outstanding write and one outstanding read, with independent read and write paths.
REQ-010 SHALL form the word index as addr[4 +: log2(MEM_DEPTH)]; addr[3:0] is ignored and size is treated as 16 B regardless of *size.
REQ-011 SHALL increment the index by 1 per beat for INCR and WRAP (wrapping modulo MEM_DEPTH), and hold it constant for FIXED.
REQ-012 SHALL run a write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE: s_awready=1 only in W_IDLE; the AW handshake latches id/index/len/burst.
REQ-013 In W_DATA it SHALL hold s_wready=1 and, on each W handshake, write the bytes enabled by s_wstrb; after exactly awlen+1 beats it SHALL enter W_RESP, with the beat count governing and s_wlast not used to terminate.
REQ-014 In W_RESP it SHALL assert s_bvalid with s_bid=latched id and hold it until s_bready, then return to W_IDLE; first AW acceptable the cycle after the B handshake.
REQ-015 SHALL run a read FSM R_IDLE -> R_DATA -> R_IDLE: s_arready=1 only in R_IDLE; the first s_rvalid SHALL rise 2 cycles after the AR handshake (1-cycle RAM read plus output register).
REQ-016 SHALL hold s_rdata/s_rid/s_rresp/s_rlast stable while s_rvalid=1 and s_rready=0, and sustain one beat per cycle while s_rready=1 (prefetch/skid register).
REQ-017 SHALL assert s_rlast on beat arlen+1 only, and return to R_IDLE after that handshake.
REQ-018 On a same-cycle read and write to one word, the read SHALL return the old data (read-first).
REQ-019 With the feature of REQ-024 absent, s_bresp and s_rresp SHALL be 2'b00 (OKAY).

Reset
REQ-020 While rstn=0 at a clk edge, both FSMs SHALL go to IDLE and s_bvalid=0, s_rvalid=0, s_rlast=0, s_bresp=0, s_rresp=0, s_awready=0, s_wready=0, s_arready=0.
REQ-021 The first cycle after reset release SHALL present s_awready=1 and s_arready=1.
REQ-022 Reset mid-burst SHALL abandon the burst without a response; memory contents are not cleared and are undefined after power-up.

Configuration
REQ-023 SHALL recognise macro AXI_MEM_RESPONDER_ERR_EN.
REQ-024 With AXI_MEM_RESPONDER_ERR_EN defined: a burst whose start address has bits above 4+log2(MEM_DEPTH) nonzero SHALL return DECERR (2'b11) on every beat/B with no memory write and rdata=0; a write whose s_wlast disagrees with the beat count SHALL return SLVERR (2'b10).
REQ-025 Without AXI_MEM_RESPONDER_ERR_EN: high address bits SHALL be ignored (alias), s_wlast SHALL be ignored, and all responses SHALL be OKAY.

Structure
REQ-026 Package axi_mem_pkg SHALL hold the burst enum (FIXED=0, INCR=1, WRAP=2), the resp enum (OKAY/EXOKAY/SLVERR/DECERR) and the localparams DATA_WIDTH=128 and ADDR_LSB=4.
REQ-027 The memory SHALL be a separate sub-module sdp_ram_be: simple dual-port, 16 byte-enables, 1-cycle registered read, read-first.

Verification
REQ-028 Single write: AW id=1 addr=0x40 len=0, W data=0xA5..A5 strb=FFFF -> B id=1 resp=0; then AR id=2 addr=0x40 -> R id=2 data=0xA5..A5 rlast=1, rvalid 2 cycles after AR.
REQ-029 INCR burst: write len=15 from 0x100 with data=beat index, read it back with s_rready toggled 1/0 each cycle -> 16 beats 0..15 in order, data stable while stalled, rlast on beat 16 only.
REQ-030 Byte strobe: write 0x0 all ones, then strb=0x000F data=0 -> read returns bytes [3:0]=0 and the rest 0xFF.
REQ-031 Wrap and FIXED: an INCR len=3 at word MEM_DEPTH-2 writes words MEM_DEPTH-2, MEM_DEPTH-1, 0, 1; a FIXED len=3 leaves only the last beat's data in its word.
REQ-032 Reset: assert rstn=0 during beat 3 of an 8-beat read -> rvalid=0 next cycle, no further R beats, arready=1 after release.
REQ-033 With AXI_MEM_RESPONDER_ERR_EN: addr=1<<40 -> resp=DECERR with no memory change; early s_wlast on beat 2 of len=3 -> bresp=SLVERR; without the macro, both cases -> OKAY.
